spi_ram_ctrl: RTL and testbench

//   Word-oriented SPI SRAM controller (23LC1024-class, SPI mode 0) between PatmosChip's

---
 rtl/spi_ram_ctrl.sv | 139 +++++++++++++
 tb/tb_spi_ram_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_ctrl.sv
// Word-oriented SPI SRAM controller (mode 0): one 32-bit read/write request becomes
// one CS-framed 64-bit transaction (cmd, 24-bit address, 32 data bits).
module spi_ram_ctrl #(
  parameter int CLK_DIV = 2,
  parameter int ADDR_W  = 24
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              spi_sclk,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [3:0]        spi_oeb
);

  localparam int CW = $clog2(CLK_DIV + 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   div_cnt;
  logic [5:0]      bit_cnt;
  logic            we_q;
  logic [62:0]     tx_sr;
  logic [31:0]     rx_sr;

  logic              accept;
  logic              half_done;
  logic              sclk_rise;
  logic              sclk_fall;
  logic [ADDR_W-1:0] wire_addr;
  logic [63:0]       frame_load;

  assign accept     = req_valid && req_ready;
  assign half_done  = (div_cnt == DIV_LAST);
  assign sclk_rise  = (state == SHIFT) && half_done && !spi_sclk;
  assign sclk_fall  = (state == SHIFT) && half_done && spi_sclk;
  assign wire_addr  = req_addr & ~ADDR_W'(3);
  assign frame_load = {(req_we ? 8'h02 : 8'h03), wire_addr, (req_we ? req_wdata : 32'h0)};
  assign spi_oeb    = 4'b1000;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'h0;
      spi_sclk   <= 1'b0;
      spi_cs_n   <= 1'b1;
      spi_mosi   <= 1'b0;
      div_cnt    <= '0;
      bit_cnt    <= 6'd0;
      we_q       <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            state     <= SETUP;
            spi_cs_n  <= 1'b0;
            spi_mosi  <= frame_load[63];
            div_cnt   <= '0;
            bit_cnt   <= 6'd63;
            we_q      <= req_we;
          end
        end
        SETUP: begin
          if (half_done) begin
            state   <= SHIFT;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // Each SCLK period is a low half then a high half; MOSI advances on the fall.
        SHIFT: begin
          if (half_done) begin
            div_cnt <= '0;
            if (!spi_sclk) begin
              spi_sclk <= 1'b1;
            end else begin
              spi_sclk <= 1'b0;
              if (bit_cnt == 6'd0) begin
                state    <= HOLD;
                spi_mosi <= 1'b0;
              end else begin
                bit_cnt  <= bit_cnt - 1'b1;
                spi_mosi <= tx_sr[62];
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        // CS stays low for CLK_DIV cycles after the last fall, then one cycle high before DONE.
        HOLD: begin
          if (spi_cs_n) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            if (!we_q) resp_rdata <= rx_sr;
          end else if (half_done) begin
            spi_cs_n <= 1'b1;
            div_cnt  <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift registers carry no reset: they are reloaded on every accepted request.
  always_ff @(posedge clock) begin
    if ((state == IDLE) && accept) begin
      tx_sr <= frame_load[62:0];
    end else if (sclk_fall) begin
      tx_sr <= {tx_sr[61:0], 1'b0};
    end
    if (sclk_rise) begin
      rx_sr <= {rx_sr[30:0], spi_miso};
    end
  end

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl at CLK_DIV = 2, 1 and 4, each with its own SPI SRAM model.
module tb_spi_ram_ctrl;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic [63:0] frame;
    logic [31:0] rdata;
  } exp_t;

  task automatic chk(input int g, input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL inst%0d %s: got 0x%0h, expected 0x%0h", g, nm, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int CD  = (g == 0) ? 2 : ((g == 1) ? 1 : 4);
    localparam int LAT = 130 * CD + 1;

    logic        reset, req_valid, req_ready, req_we, resp_valid;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [23:0] req_addr;
    logic [31:0] req_wdata, resp_rdata;
    logic [3:0]  spi_oeb;
    bit          fin = 1'b0;

    spi_ram_ctrl #(.CLK_DIV(CD), .ADDR_W(24)) dut (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .spi_sclk(spi_sclk),
      .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_oeb(spi_oeb)
    );

    exp_t exp_q[$];
    int   acc_q[$];
    int   cyc = 0;
    int   acc_cnt = 0;
    int   acc_last = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
      if (reset === 1'b0 && req_valid === 1'b1 && req_ready === 1'b1) begin
        acc_q.push_back(cyc);
        acc_cnt  <= acc_cnt + 1;
        acc_last <= cyc;
      end
    end

    // SPI SRAM model: samples MOSI on SCLK rise, drives MISO on SCLK fall.
    logic [31:0] mem [logic [23:0]];
    logic [63:0] fr = '0;
    logic [63:0] last_frame = '0;
    logic [31:0] rdw = '0;
    int          nb = 0;

    always @(negedge spi_cs_n) begin
      nb = 0;
      fr = '0;
    end
    always @(posedge spi_sclk) begin
      if (spi_cs_n === 1'b0) begin
        fr = {fr[62:0], spi_mosi};
        nb++;
        if (nb == 32) rdw = mem.exists(fr[23:0]) ? mem[fr[23:0]] : 32'h0;
      end
    end
    always @(negedge spi_sclk) begin
      if (spi_cs_n === 1'b0 && nb >= 32 && nb < 64) spi_miso = rdw[63 - nb];
      else spi_miso = 1'b0;
    end
    always @(posedge spi_cs_n) begin
      last_frame = fr;
      if (nb == 64 && fr[63:56] == 8'h02) mem[fr[55:32]] = fr[31:0];
    end

    // Mode-0 protocol watcher
    int   proto_err = 0;
    int   last_rise = -1;
    int   hi_cnt = 0;
    logic ps = 1'b0, pm = 1'b0, pc = 1'b1;
    always @(negedge clock) begin
      if (reset === 1'b0) begin
        if (spi_cs_n && spi_sclk) proto_err++;
        if (!spi_cs_n && ps && spi_sclk && spi_mosi !== pm) proto_err++;
        if (spi_sclk && !ps) begin
          if (last_rise >= 0 && (cyc - last_rise) != 2 * CD) proto_err++;
          last_rise = cyc;
        end
        if (spi_cs_n) begin
          last_rise = -1;
          hi_cnt++;
        end else if (pc) begin
          if (hi_cnt < 2) proto_err++;
          hi_cnt = 0;
        end
      end
      ps = spi_sclk;
      pm = spi_mosi;
      pc = spi_cs_n;
    end

    // Monitor: pops one expectation per response pulse.
    always @(negedge clock) begin
      exp_t e;
      int   a;
      if (resp_valid === 1'b1) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          nvec++;
          nerr++;
          $display("FAIL inst%0d unexpected_resp: resp_valid=1, expected no response", g);
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          chk(g, "latency", 64'(cyc - a - 1), 64'(LAT));
          chk(g, "resp_rdata", {32'h0, resp_rdata}, {32'h0, e.rdata});
          chk(g, "mosi_frame", last_frame, e.frame);
        end
      end
    end

    task automatic send(input bit we, input logic [23:0] a, input logic [31:0] d,
                        input logic [63:0] efr, input logic [31:0] erd, input bit keep);
      exp_t e;
      int   c0;
      int   t;
      e.frame   = efr;
      e.rdata   = erd;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
      exp_q.push_back(e);
      c0 = acc_cnt;
      t  = 0;
      while (acc_cnt == c0 && t < 2000) begin
        @(negedge clock);
        t++;
      end
      if (acc_cnt == c0) begin
        chk(g, "accept_timeout", 64'(acc_cnt), 64'(c0 + 1));
        void'(exp_q.pop_back());
      end
      if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 4000) begin
        @(negedge clock);
        t++;
      end
      chk(g, "resp_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
      repeat (3) @(negedge clock);
    endtask

    initial begin
      int c0;
      int t;
      int a1;
      reset     = 1'b1;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = 24'h0;
      req_wdata = 32'h0;
      spi_miso  = 1'b0;
      repeat (3) @(negedge clock);
      chk(g, "rst_req_ready", {63'h0, req_ready}, 64'd0);
      chk(g, "rst_resp_valid", {63'h0, resp_valid}, 64'd0);
      chk(g, "rst_resp_rdata", {32'h0, resp_rdata}, 64'd0);
      chk(g, "rst_sclk", {63'h0, spi_sclk}, 64'd0);
      chk(g, "rst_cs_n", {63'h0, spi_cs_n}, 64'd1);
      chk(g, "rst_mosi", {63'h0, spi_mosi}, 64'd0);
      chk(g, "spi_oeb", {60'h0, spi_oeb}, 64'h8);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      chk(g, "idle_req_ready", {63'h0, req_ready}, 64'd1);

      // Abort a write mid-SHIFT with reset.
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_addr  = 24'h000200;
      req_wdata = 32'h55AA55AA;
      c0 = acc_cnt;
      t  = 0;
      while (acc_cnt == c0 && t < 100) begin
        @(negedge clock);
        t++;
      end
      req_valid = 1'b0;
      chk(g, "abort_accept", 64'(acc_cnt), 64'(c0 + 1));
      repeat (40 * CD) @(negedge clock);
      chk(g, "mid_shift_cs_n", {63'h0, spi_cs_n}, 64'd0);
      reset = 1'b1;
      #1;
      chk(g, "abort_cs_n", {63'h0, spi_cs_n}, 64'd1);
      chk(g, "abort_sclk", {63'h0, spi_sclk}, 64'd0);
      acc_q.delete();
      @(negedge clock);
      reset = 1'b0;
      repeat (150 * CD) @(negedge clock);
      chk(g, "abort_req_ready", {63'h0, req_ready}, 64'd1);

      send(1'b1, 24'h000104, 32'hDEADBEEF, 64'h02000104_DEADBEEF, 32'h00000000, 1'b0);
      wait_idle();
      send(1'b0, 24'h000104, 32'h00000000, 64'h03000104_00000000, 32'hDEADBEEF, 1'b0);
      wait_idle();
      send(1'b1, 24'h123457, 32'h12345678, 64'h02123454_12345678, 32'hDEADBEEF, 1'b0);
      wait_idle();

      // Back-to-back with req_valid held: read, then write that must not disturb resp_rdata.
      send(1'b0, 24'h123457, 32'hFFFFFFFF, 64'h03123454_00000000, 32'h12345678, 1'b1);
      a1 = acc_last;
      send(1'b1, 24'hFFFFFC, 32'hCAFEF00D, 64'h02FFFFFC_CAFEF00D, 32'h12345678, 1'b0);
      chk(g, "b2b_accept_gap", 64'(acc_last - a1), 64'(130 * CD + 3));
      wait_idle();

      send(1'b0, 24'hFFFFFF, 32'h00000000, 64'h03FFFFFC_00000000, 32'hCAFEF00D, 1'b0);
      wait_idle();
      chk(g, "mode0_protocol", 64'(proto_err), 64'd0);
      fin = 1'b1;
    end
  end

  initial begin
    int t;
    t = 0;
    while (!(inst[0].fin && inst[1].fin && inst[2].fin) && t < 60000) begin
      @(negedge clock);
      t++;
    end
    if (!(inst[0].fin && inst[1].fin && inst[2].fin)) begin
      nvec++;
      nerr++;
      $display("FAIL global_timeout: sequences unfinished after %0d cycles, expected completion", t);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
